stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core. Produces the 4-bit `stage` consumed by the select-bit decoder and the per-stage enables (IR, PC, register commit, memory commit).
- Picks each instruction's stage path from its opcode class.
- Handles the memory ready handshake, a memory-timeout watchdog and a sticky fault state.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for mem_ready in FETCH/MEMORY before fault; 0 disables the watchdog.
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0] from IR; valid from DECODE onward
- mem_ready  in  1  memory completed the current request this cycle
- stage  out  4  FETCH=4'b0000, DECODE=4'b0001, EXECUTE=4'b0010, MEMORY=4'b0100, WRITEBACK=4'b1000, FAULT=4'b1111
- mem_req  out  1  memory request active (FETCH and MEMORY)
- ir_wen  out  1  load IR
- pc_wen  out  1  update PC (next-PC mux is external)
- reg_commit  out  1  gates register-file write enable
- mem_commit  out  1  gates memory write enable
- instr_done  out  1  one-cycle pulse on instruction retire
- fault  out  1  sticky fault flag
- fault_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (synchronous) from any state, including mid-wait:
  - state=FETCH, wait counter=0, latched class=NONE, fault=0, fault_cause=00.
  - While reset is high, all outputs are 0 and stage=4'b0000.
- Outputs are a combinational (Moore) function of state, plus mem_ready where noted.
- FETCH:
  - mem_req=1.
  - If mem_ready=1: ir_wen=1, go to DECODE. Otherwise stay.
- DECODE:
  - Classify opcode and latch the class.
  - Later stages use the latched class only, so IR changes after DECODE have no effect.
  - Legal classes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: go to FAULT with cause 01, with no PC or register side effects.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Load or store: go to MEMORY.
  - Branch: pc_wen=1, instr_done=1, go to FETCH. The taken/not-taken choice is made in the PC block.
  - All other classes: go to WRITEBACK.
- MEMORY:
  - mem_req=1; mem_commit=1 for stores only, held level for the whole stay.
  - On mem_ready=1, a load goes to WRITEBACK.
  - On mem_ready=1, a store asserts pc_wen=1 and instr_done=1, then goes to FETCH.
  - Otherwise stay.
- WRITEBACK:
  - reg_commit=1, pc_wen=1, instr_done=1, go to FETCH.
  - Exactly one cycle, every register-writing class.
- Instruction latency with zero-wait memory:
  - ALU, U-type and jumps: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Watchdog (MEM_TIMEOUT>0):
  - The wait counter clears on entry to FETCH/MEMORY and increments each cycle mem_ready=0.
  - When the counter equals MEM_TIMEOUT and mem_ready=0: go to FAULT, cause 10.
  - If mem_ready=1 and the count limit occur in the same cycle, mem_ready wins and there is no fault.
- FAULT:
  - stage=4'b1111, fault=1, and every enable is 0.
  - Leaves only on reset.
- pc_wen and instr_done are asserted in the same cycle, exactly once per retired instruction.
- reg_commit and mem_commit are never high in the same cycle.

Optional Feature:
- Macro STAGE_SEQUENCER_PERF_EN. When defined, adds two ports:
  - cycle_count (out, CNT_W): +1 every non-reset cycle outside FAULT.
  - instret_count (out, CNT_W): +1 on each instr_done.
  - Both clear on reset, wrap modulo 2^CNT_W, and freeze in FAULT.
- When undefined: neither port nor counter exists, and core behaviour is identical.

Test Plan:
- ADD (0110011), mem_ready always 1 -> stage 0,1,2,8,0; ir_wen in cycle 1; reg_commit, pc_wen and instr_done in cycle 4; mem_commit never 1.
- LW (0000011), mem_ready low 2 cycles in MEMORY -> stage 0,1,2,4,4,4,8; reg_commit in cycle 7 only.
- SW (0100011), mem_ready=1 -> stage 0,1,2,4,0; mem_commit=1 and pc_wen=1 in the MEMORY cycle; reg_commit never 1.
- BEQ (1100011) then opcode 0000000 -> branch retires after 3 cycles; next DECODE enters FAULT, stage=4'b1111, fault_cause=01; pc_wen stays 0 until reset.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after the 5th FETCH cycle, fault_cause=10. Repeat with mem_ready=1 on the limit cycle -> no fault.
- Assert reset in MEMORY of a store -> next cycle stage=0, fault=0, mem_commit=0. With STAGE_SEQUENCER_PERF_EN, 3 ADDs give instret_count=3 and cycle_count=12.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the RV32I core: stage code, per-stage enables, memory watchdog, sticky fault.
// Optional performance counters are compiled in with `define STAGE_SEQUENCER_PERF_EN.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [3:0]       stage,
    output logic             mem_req,
    output logic             ir_wen,
    output logic             pc_wen,
    output logic             reg_commit,
    output logic             mem_commit,
    output logic             instr_done,
    output logic             fault,
    output logic [1:0]       fault_cause
`ifdef STAGE_SEQUENCER_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_REG    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } cls_t;

    localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic            WDOG_EN    = (MEM_TIMEOUT > 0);

    // ALU, U-type and jumps all retire through WRITEBACK, so they share one class.
    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: classify = CLS_REG;
            7'b0000011:                         classify = CLS_LOAD;
            7'b0100011:                         classify = CLS_STORE;
            7'b1100011:                         classify = CLS_BRANCH;
            default:                            classify = CLS_NONE;
        endcase
    endfunction

    state_t            state_r;
    cls_t              cls_r;
    cls_t              cls_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [1:0]        cause_r;
    logic              timeout_s;

    assign cls_s     = classify(opcode);
    // mem_ready takes priority over the limit in the same cycle.
    assign timeout_s = WDOG_EN && !mem_ready && (wait_cnt_r == WAIT_LIMIT);

    // State, latched class, watchdog counter and fault cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            cls_r      <= CLS_NONE;
            wait_cnt_r <= '0;
            cause_r    <= 2'b00;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        state_r <= ST_FAULT;
                        cause_r <= 2'b10;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
                    end
                end
                ST_DECODE: begin
                    cls_r <= cls_s;
                    if (cls_s == CLS_NONE) begin
                        state_r <= ST_FAULT;
                        cause_r <= 2'b01;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (cls_r)
                        CLS_LOAD, CLS_STORE: begin
                            state_r    <= ST_MEMORY;
                            wait_cnt_r <= '0;
                        end
                        CLS_BRANCH: begin
                            state_r    <= ST_FETCH;
                            wait_cnt_r <= '0;
                        end
                        CLS_REG: state_r <= ST_WRITEBACK;
                        default: begin
                            state_r <= ST_FAULT;
                            cause_r <= 2'b01;
                        end
                    endcase
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        if (cls_r == CLS_LOAD) begin
                            state_r <= ST_WRITEBACK;
                        end else begin
                            state_r    <= ST_FETCH;
                            wait_cnt_r <= '0;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_FAULT;
                        cause_r <= 2'b10;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
                    end
                end
                ST_WRITEBACK: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= '0;
                end
                ST_FAULT: state_r <= ST_FAULT;
                default:  state_r <= ST_FAULT;
            endcase
        end
    end

    // Moore decode of stage and enables; everything is forced low while reset is held.
    always_comb begin
        stage      = 4'b0000;
        mem_req    = 1'b0;
        ir_wen     = 1'b0;
        pc_wen     = 1'b0;
        reg_commit = 1'b0;
        mem_commit = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        if (reset) begin
            stage = 4'b0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_wen  = mem_ready;
                end
                ST_DECODE: stage = 4'b0001;
                ST_EXECUTE: begin
                    stage = 4'b0010;
                    if (cls_r == CLS_BRANCH) begin
                        pc_wen     = 1'b1;
                        instr_done = 1'b1;
                    end else begin
                        pc_wen     = 1'b0;
                    end
                end
                ST_MEMORY: begin
                    stage      = 4'b0100;
                    mem_req    = 1'b1;
                    mem_commit = (cls_r == CLS_STORE);
                    if ((cls_r == CLS_STORE) && mem_ready) begin
                        pc_wen     = 1'b1;
                        instr_done = 1'b1;
                    end else begin
                        pc_wen     = 1'b0;
                    end
                end
                ST_WRITEBACK: begin
                    stage      = 4'b1000;
                    reg_commit = 1'b1;
                    pc_wen     = 1'b1;
                    instr_done = 1'b1;
                end
                ST_FAULT: begin
                    stage = 4'b1111;
                    fault = 1'b1;
                end
                default: begin
                    stage = 4'b1111;
                    fault = 1'b1;
                end
            endcase
        end
    end

    assign fault_cause = reset ? 2'b00 : cause_r;

`ifdef STAGE_SEQUENCER_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;

    // Performance counters; frozen while faulted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
        end else if (!fault) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
            if (instr_done) begin
                instret_cnt_r <= instret_cnt_r + CNT_W'(1'b1);
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end else begin
            cycle_cnt_r   <= cycle_cnt_r;
            instret_cnt_r <= instret_cnt_r;
        end
    end

    assign cycle_count   = reset ? '0 : cycle_cnt_r;
    assign instret_count = reset ? '0 : instret_cnt_r;
`endif

endmodule
